// File: rtl/int_sequencer.sv
// int_sequencer: multi-cycle controller for interrupt entry and RTI return.
// While busy it owns the data-memory port and the front pipeline stall/flush
// lines. Entry drains the pipe, pushes PC high/low and flags, then fetches the
// new PC from the vector table. RTI pops flags, PC low and PC high, then
// reloads them. All state advances on the falling clock edge to line up with
// the pipeline buffers.
module int_sequencer #(
    parameter int                    PC_WIDTH     = 32,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    FLAGS_WIDTH  = 3,
    parameter int                    DRAIN_CYCLES = 3,
    parameter logic [DATA_WIDTH-1:0] VEC_BASE     = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   int_req,
    input  logic                   rti_req,
    input  logic                   mem_busy,
    input  logic [PC_WIDTH-1:0]    pc_cur,
    input  logic [FLAGS_WIDTH-1:0] flags_cur,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   stall_front,
    output logic                   flush_front,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [DATA_WIDTH-1:0]  mem_addr,
    output logic                   addr_sp,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [1:0]             sp_op,
    output logic                   pc_load,
    output logic [PC_WIDTH-1:0]    pc_load_val,
    output logic                   flags_load,
    output logic [FLAGS_WIDTH-1:0] flags_load_val,
    output logic                   int_ack,
    output logic                   busy
);

    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0]      DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES);
    localparam logic [DATA_WIDTH-1:0] VEC_LO_ADDR = VEC_BASE + DATA_WIDTH'(1);

    localparam logic [1:0] SP_NONE = 2'b00;
    localparam logic [1:0] SP_PUSH = 2'b01;
    localparam logic [1:0] SP_POP  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_HI,
        S_PUSH_LO,
        S_PUSH_FL,
        S_VEC_HI,
        S_VEC_LO,
        S_POP_FL,
        S_POP_LO,
        S_POP_HI,
        S_DONE
    } state_t;

    state_t                 state;
    logic                   rti_mode;
    logic                   pending;
    logic [CNT_W-1:0]       drain_cnt;
    logic [CNT_W-1:0]       cnt_dec;
    logic [PC_WIDTH-1:0]    hold_pc;
    logic [FLAGS_WIDTH-1:0] hold_flags;
    logic [DATA_WIDTH-1:0]  hi_hold;
    logic [DATA_WIDTH-1:0]  lo_hold;
    logic [FLAGS_WIDTH-1:0] pop_flags;

    // Saturating decrement of the drain counter; DRAIN exits on the cycle the
    // decremented value reaches zero so it lasts exactly DRAIN_CYCLES cycles.
    always_comb begin
        cnt_dec = drain_cnt;
        if (drain_cnt != '0) begin
            cnt_dec = drain_cnt - CNT_W'(1);
        end
    end

    // Sequencer state, pending latch and the hold registers for PC/flags data.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rti_mode   <= 1'b0;
            pending    <= 1'b0;
            drain_cnt  <= '0;
            hold_pc    <= '0;
            hold_flags <= '0;
            hi_hold    <= '0;
            lo_hold    <= '0;
            pop_flags  <= '0;
        end else begin
            pending <= int_req | (pending & ~int_ack);
            case (state)
                S_IDLE: begin
                    if (rti_req) begin
                        rti_mode <= 1'b1;
                        state    <= S_POP_FL;
                    end else if (pending) begin
                        rti_mode   <= 1'b0;
                        hold_pc    <= pc_cur;
                        hold_flags <= flags_cur;
                        drain_cnt  <= DRAIN_LOAD;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= cnt_dec;
                    if (cnt_dec == '0 && !mem_busy) begin
                        state <= S_PUSH_HI;
                    end
                end
                S_PUSH_HI: state <= S_PUSH_LO;
                S_PUSH_LO: state <= S_PUSH_FL;
                S_PUSH_FL: state <= S_VEC_HI;
                S_VEC_HI:  state <= S_VEC_LO;
                S_VEC_LO: begin
                    hi_hold <= mem_rdata;
                    state   <= S_DONE;
                end
                S_POP_FL:  state <= S_POP_LO;
                S_POP_LO: begin
                    pop_flags <= mem_rdata[FLAGS_WIDTH-1:0];
                    state     <= S_POP_HI;
                end
                S_POP_HI: begin
                    lo_hold <= mem_rdata;
                    state   <= S_DONE;
                end
                S_DONE:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Output decode from the registered state; DONE forwards the word that
    // arrives on mem_rdata this cycle as the last half of the new PC.
    always_comb begin
        stall_front    = 1'b0;
        flush_front    = 1'b0;
        busy           = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        addr_sp        = 1'b0;
        mem_wdata      = '0;
        sp_op          = SP_NONE;
        pc_load        = 1'b0;
        pc_load_val    = '0;
        flags_load     = 1'b0;
        flags_load_val = '0;
        int_ack        = 1'b0;

        if (state != S_IDLE) begin
            stall_front = 1'b1;
            flush_front = 1'b1;
            busy        = 1'b1;
        end

        case (state)
            S_PUSH_HI, S_PUSH_LO, S_PUSH_FL: begin
                mem_en  = 1'b1;
                mem_we  = 1'b1;
                addr_sp = 1'b1;
                sp_op   = SP_PUSH;
                if (state == S_PUSH_HI) begin
                    mem_wdata = hold_pc[PC_WIDTH-1:DATA_WIDTH];
                end else if (state == S_PUSH_LO) begin
                    mem_wdata = hold_pc[DATA_WIDTH-1:0];
                end else begin
                    mem_wdata = DATA_WIDTH'(hold_flags);
                end
            end
            S_VEC_HI: begin
                mem_en   = 1'b1;
                mem_addr = VEC_BASE;
            end
            S_VEC_LO: begin
                mem_en   = 1'b1;
                mem_addr = VEC_LO_ADDR;
            end
            S_POP_FL, S_POP_LO, S_POP_HI: begin
                mem_en  = 1'b1;
                addr_sp = 1'b1;
                sp_op   = SP_POP;
            end
            S_DONE: begin
                pc_load = 1'b1;
                if (rti_mode) begin
                    pc_load_val    = {mem_rdata, lo_hold};
                    flags_load     = 1'b1;
                    flags_load_val = pop_flags;
                end else begin
                    pc_load_val = {hi_hold, mem_rdata};
                    int_ack     = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed testbench for int_sequencer. Each task walks a hand-written
// per-cycle table of expected control outputs and data words.
module tb_int_sequencer;

    logic        clk;
    logic        reset;
    logic        int_req;
    logic        rti_req;
    logic        mem_busy;
    logic [31:0] pc_cur;
    logic [2:0]  flags_cur;
    logic [15:0] mem_rdata;
    logic        stall_front;
    logic        flush_front;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic        addr_sp;
    logic [15:0] mem_wdata;
    logic [1:0]  sp_op;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic        flags_load;
    logic [2:0]  flags_load_val;
    logic        int_ack;
    logic        busy;

    int vectors;
    int miscompares;

    // {busy, stall, flush, mem_en, mem_we, addr_sp, sp_op[1:0], pc_load, flags_load, int_ack}
    localparam logic [10:0] C_IDLE   = 11'b000_000_00_000;
    localparam logic [10:0] C_DRAIN  = 11'b111_000_00_000;
    localparam logic [10:0] C_PUSH   = 11'b111_111_01_000;
    localparam logic [10:0] C_VEC    = 11'b111_100_00_000;
    localparam logic [10:0] C_POP    = 11'b111_101_10_000;
    localparam logic [10:0] C_DONE_E = 11'b111_000_00_101;
    localparam logic [10:0] C_DONE_R = 11'b111_000_00_110;

    logic [10:0] ctl;
    assign ctl = {busy, stall_front, flush_front, mem_en, mem_we, addr_sp,
                  sp_op, pc_load, flags_load, int_ack};

    int_sequencer #(
        .PC_WIDTH     (32),
        .DATA_WIDTH   (16),
        .FLAGS_WIDTH  (3),
        .DRAIN_CYCLES (3),
        .VEC_BASE     (16'h0FF0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .int_req        (int_req),
        .rti_req        (rti_req),
        .mem_busy       (mem_busy),
        .pc_cur         (pc_cur),
        .flags_cur      (flags_cur),
        .mem_rdata      (mem_rdata),
        .stall_front    (stall_front),
        .flush_front    (flush_front),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .addr_sp        (addr_sp),
        .mem_wdata      (mem_wdata),
        .sp_op          (sp_op),
        .pc_load        (pc_load),
        .pc_load_val    (pc_load_val),
        .flags_load     (flags_load),
        .flags_load_val (flags_load_val),
        .int_ack        (int_ack),
        .busy           (busy)
    );

    // Clock: DUT acts on negedge, bench drives and samples just after posedge.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (ctl !== C_IDLE || pc_load_val !== 32'h0 || flags_load_val !== 3'b0 ||
                mem_wdata !== 16'h0 || mem_addr !== 16'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs: ctl=%b pc=%h fl=%b wd=%h ad=%h, want all zero",
                         ctl, pc_load_val, flags_load_val, mem_wdata, mem_addr);
            end
        end
        @(posedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++;
            $display("[TB] FAIL reset_release: ctl=%b, want %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_basic_entry();
        logic [10:0] exp_ctl [0:11];
        logic [15:0] wd [0:11];
        logic [15:0] ad [0:11];
        logic [15:0] rd [0:11];
        logic [31:0] pcx [0:11];
        exp_ctl = '{C_IDLE, C_IDLE, C_DRAIN, C_DRAIN, C_DRAIN, C_PUSH, C_PUSH, C_PUSH,
                    C_VEC, C_VEC, C_DONE_E, C_IDLE};
        for (int k = 0; k < 12; k++) begin
            wd[k] = 16'h0; ad[k] = 16'h0; rd[k] = 16'hA5A5; pcx[k] = 32'h0;
        end
        wd[5] = 16'h0001; wd[6] = 16'h0234; wd[7] = 16'h0005;
        ad[8] = 16'h0FF0; ad[9] = 16'h0FF1;
        rd[9] = 16'h0000; rd[10] = 16'h0100; pcx[10] = 32'h0000_0100;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            int_req   = (k == 0);
            pc_cur    = (k <= 1) ? 32'h0001_0234 : 32'hDEAD_BEEF;
            flags_cur = (k <= 1) ? 3'b101 : 3'b010;
            mem_rdata = rd[k];
            #1;
            vectors++;
            if (ctl !== exp_ctl[k]) begin
                miscompares++;
                $display("[TB] FAIL entry_ctl c%0d: got %b, want %b", k, ctl, exp_ctl[k]);
            end
            if (exp_ctl[k] == C_PUSH) begin
                vectors++;
                if (mem_wdata !== wd[k]) begin
                    miscompares++;
                    $display("[TB] FAIL entry_wdata c%0d: got %h, want %h", k, mem_wdata, wd[k]);
                end
            end
            if (exp_ctl[k][7]) begin
                vectors++;
                if (mem_addr !== ad[k]) begin
                    miscompares++;
                    $display("[TB] FAIL entry_addr c%0d: got %h, want %h", k, mem_addr, ad[k]);
                end
            end
            if (exp_ctl[k] == C_DONE_E) begin
                vectors++;
                if (pc_load_val !== pcx[k]) begin
                    miscompares++;
                    $display("[TB] FAIL entry_pc c%0d: got %h, want %h", k, pc_load_val, pcx[k]);
                end
            end
        end
        int_req = 1'b0;
    endtask

    task automatic test_mem_busy();
        logic [10:0] exp_ctl [0:13];
        logic [15:0] wd [0:13];
        logic [15:0] ad [0:13];
        logic [15:0] rd [0:13];
        logic [31:0] pcx [0:13];
        exp_ctl = '{C_IDLE, C_IDLE, C_DRAIN, C_DRAIN, C_DRAIN, C_DRAIN, C_DRAIN,
                    C_PUSH, C_PUSH, C_PUSH, C_VEC, C_VEC, C_DONE_E, C_IDLE};
        for (int k = 0; k < 14; k++) begin
            wd[k] = 16'h0; ad[k] = 16'h0; rd[k] = 16'h5A5A; pcx[k] = 32'h0;
        end
        wd[7] = 16'h1234; wd[8] = 16'h5678; wd[9] = 16'h0003;
        ad[10] = 16'h0FF0; ad[11] = 16'h0FF1;
        rd[11] = 16'h0002; rd[12] = 16'h0300; pcx[12] = 32'h0002_0300;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            int_req   = (k == 0);
            rti_req   = (k == 3);
            mem_busy  = (k >= 2 && k <= 5);
            pc_cur    = (k <= 1) ? 32'h1234_5678 : 32'hCAFE_F00D;
            flags_cur = (k <= 1) ? 3'b011 : 3'b100;
            mem_rdata = rd[k];
            #1;
            vectors++;
            if (ctl !== exp_ctl[k]) begin
                miscompares++;
                $display("[TB] FAIL busy_ctl c%0d: got %b, want %b", k, ctl, exp_ctl[k]);
            end
            if (exp_ctl[k] == C_PUSH) begin
                vectors++;
                if (mem_wdata !== wd[k]) begin
                    miscompares++;
                    $display("[TB] FAIL busy_wdata c%0d: got %h, want %h", k, mem_wdata, wd[k]);
                end
            end
            if (exp_ctl[k][7]) begin
                vectors++;
                if (mem_addr !== ad[k]) begin
                    miscompares++;
                    $display("[TB] FAIL busy_addr c%0d: got %h, want %h", k, mem_addr, ad[k]);
                end
            end
            if (exp_ctl[k] == C_DONE_E) begin
                vectors++;
                if (pc_load_val !== pcx[k]) begin
                    miscompares++;
                    $display("[TB] FAIL busy_pc c%0d: got %h, want %h", k, pc_load_val, pcx[k]);
                end
            end
        end
        int_req = 1'b0; rti_req = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic test_rti();
        logic [10:0] exp_ctl [0:5];
        logic [15:0] rd [0:5];
        exp_ctl = '{C_IDLE, C_POP, C_POP, C_POP, C_DONE_R, C_IDLE};
        rd = '{16'h7777, 16'h7777, 16'h0005, 16'h0234, 16'h0001, 16'h7777};
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            rti_req   = (k == 0);
            pc_cur    = 32'hFFFF_FFFF;
            flags_cur = 3'b111;
            mem_rdata = rd[k];
            #1;
            vectors++;
            if (ctl !== exp_ctl[k]) begin
                miscompares++;
                $display("[TB] FAIL rti_ctl c%0d: got %b, want %b", k, ctl, exp_ctl[k]);
            end
            if (exp_ctl[k][7]) begin
                vectors++;
                if (mem_addr !== 16'h0) begin
                    miscompares++;
                    $display("[TB] FAIL rti_addr c%0d: got %h, want 0000", k, mem_addr);
                end
            end
            if (exp_ctl[k] == C_DONE_R) begin
                vectors++;
                if (pc_load_val !== 32'h0001_0234 || flags_load_val !== 3'b101) begin
                    miscompares++;
                    $display("[TB] FAIL rti_reload: pc=%h fl=%b, want 00010234 101",
                             pc_load_val, flags_load_val);
                end
            end
        end
        rti_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_ctl [0:15];
        logic [15:0] wd [0:15];
        logic [15:0] ad [0:15];
        logic [15:0] rd [0:15];
        logic [31:0] pcx [0:15];
        exp_ctl = '{C_IDLE, C_POP, C_POP, C_POP, C_DONE_R, C_IDLE, C_DRAIN, C_DRAIN,
                    C_DRAIN, C_PUSH, C_PUSH, C_PUSH, C_VEC, C_VEC, C_DONE_E, C_IDLE};
        for (int k = 0; k < 16; k++) begin
            wd[k] = 16'h0; ad[k] = 16'h0; rd[k] = 16'h3C3C; pcx[k] = 32'h0;
        end
        rd[2] = 16'h0006; rd[3] = 16'h4321; rd[4] = 16'h0007; pcx[4] = 32'h0007_4321;
        wd[9] = 16'h0ABC; wd[10] = 16'h0DEF; wd[11] = 16'h0001;
        ad[12] = 16'h0FF0; ad[13] = 16'h0FF1;
        rd[13] = 16'h0000; rd[14] = 16'h0200; pcx[14] = 32'h0000_0200;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            int_req   = (k == 0);
            rti_req   = (k == 0);
            pc_cur    = (k <= 5) ? 32'h0ABC_0DEF : 32'h9999_8888;
            flags_cur = (k <= 5) ? 3'b001 : 3'b110;
            mem_rdata = rd[k];
            #1;
            vectors++;
            if (ctl !== exp_ctl[k]) begin
                miscompares++;
                $display("[TB] FAIL b2b_ctl c%0d: got %b, want %b", k, ctl, exp_ctl[k]);
            end
            if (exp_ctl[k] == C_PUSH) begin
                vectors++;
                if (mem_wdata !== wd[k]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_wdata c%0d: got %h, want %h", k, mem_wdata, wd[k]);
                end
            end
            if (exp_ctl[k][7]) begin
                vectors++;
                if (mem_addr !== ad[k]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_addr c%0d: got %h, want %h", k, mem_addr, ad[k]);
                end
            end
            if (exp_ctl[k] == C_DONE_E || exp_ctl[k] == C_DONE_R) begin
                vectors++;
                if (pc_load_val !== pcx[k]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_pc c%0d: got %h, want %h", k, pc_load_val, pcx[k]);
                end
            end
            if (exp_ctl[k] == C_DONE_R) begin
                vectors++;
                if (flags_load_val !== 3'b110) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_flags c%0d: got %b, want 110", k, flags_load_val);
                end
            end
        end
        int_req = 1'b0; rti_req = 1'b0;
    endtask

    task automatic test_int_during_entry();
        logic [10:0] exp_ctl [0:26];
        logic [15:0] wd [0:26];
        logic [15:0] ad [0:26];
        logic [15:0] rd [0:26];
        logic [31:0] pcx [0:26];
        exp_ctl = '{C_IDLE, C_IDLE, C_DRAIN, C_DRAIN, C_DRAIN, C_PUSH, C_PUSH, C_PUSH,
                    C_VEC, C_VEC, C_DONE_E, C_IDLE, C_IDLE, C_IDLE, C_IDLE,
                    C_DRAIN, C_DRAIN, C_DRAIN, C_PUSH, C_PUSH, C_PUSH, C_VEC, C_VEC,
                    C_DONE_E, C_IDLE, C_DRAIN, C_DRAIN};
        for (int k = 0; k < 27; k++) begin
            wd[k] = 16'h0; ad[k] = 16'h0; rd[k] = 16'hBEEF; pcx[k] = 32'h0;
        end
        wd[5] = 16'h1111; wd[6] = 16'h2222; wd[7] = 16'h0004;
        wd[18] = 16'h1111; wd[19] = 16'h2222; wd[20] = 16'h0004;
        ad[8] = 16'h0FF0; ad[9] = 16'h0FF1; ad[21] = 16'h0FF0; ad[22] = 16'h0FF1;
        rd[9] = 16'h0003; rd[10] = 16'h0400; pcx[10] = 32'h0003_0400;
        rd[22] = 16'h0004; rd[23] = 16'h0500; pcx[23] = 32'h0004_0500;
        for (int k = 0; k < 27; k++) begin
            @(posedge clk);
            int_req   = (k == 0 || k == 3 || k == 13 || k == 23);
            pc_cur    = 32'h1111_2222;
            flags_cur = 3'b100;
            mem_rdata = rd[k];
            #1;
            vectors++;
            if (ctl !== exp_ctl[k]) begin
                miscompares++;
                $display("[TB] FAIL during_ctl c%0d: got %b, want %b", k, ctl, exp_ctl[k]);
            end
            if (exp_ctl[k] == C_PUSH) begin
                vectors++;
                if (mem_wdata !== wd[k]) begin
                    miscompares++;
                    $display("[TB] FAIL during_wdata c%0d: got %h, want %h", k, mem_wdata, wd[k]);
                end
            end
            if (exp_ctl[k][7]) begin
                vectors++;
                if (mem_addr !== ad[k]) begin
                    miscompares++;
                    $display("[TB] FAIL during_addr c%0d: got %h, want %h", k, mem_addr, ad[k]);
                end
            end
            if (exp_ctl[k] == C_DONE_E) begin
                vectors++;
                if (pc_load_val !== pcx[k]) begin
                    miscompares++;
                    $display("[TB] FAIL during_pc c%0d: got %h, want %h", k, pc_load_val, pcx[k]);
                end
            end
        end
        int_req = 1'b0;
    endtask

    // Continues the entry left in DRAIN by test_int_during_entry.
    task automatic test_reset_mid();
        logic [10:0] exp_ctl [0:9];
        exp_ctl = '{C_DRAIN, C_PUSH, C_PUSH, C_IDLE, C_IDLE, C_IDLE, C_IDLE, C_IDLE,
                    C_IDLE, C_IDLE};
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            int_req   = (k >= 2 && k <= 4);
            mem_rdata = 16'hFFFF;
            if (k == 5) reset = 1'b1;
            #1;
            vectors++;
            if (ctl !== exp_ctl[k]) begin
                miscompares++;
                $display("[TB] FAIL rstmid_ctl c%0d: got %b, want %b", k, ctl, exp_ctl[k]);
            end
            if (k == 2) begin
                vectors++;
                if (mem_wdata !== 16'h2222) begin
                    miscompares++;
                    $display("[TB] FAIL rstmid_pushlo: got %h, want 2222", mem_wdata);
                end
                reset = 1'b0;
                #1;
                vectors++;
                if (ctl !== C_IDLE || mem_wdata !== 16'h0 || mem_addr !== 16'h0 ||
                    pc_load_val !== 32'h0 || flags_load_val !== 3'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rstmid_async: ctl=%b wd=%h ad=%h pc=%h fl=%b, want all zero",
                             ctl, mem_wdata, mem_addr, pc_load_val, flags_load_val);
                end
            end
        end
        int_req = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        int_req     = 1'b0;
        rti_req     = 1'b0;
        mem_busy    = 1'b0;
        pc_cur      = 32'h0;
        flags_cur   = 3'b0;
        mem_rdata   = 16'h0;

        test_reset();
        test_basic_entry();
        test_mem_busy();
        test_rti();
        test_back_to_back();
        test_int_during_entry();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
